// File: rtl/demux1to2_if.sv
// Beat-level handshake bundle for the 1-to-2 packet demultiplexer.
// The slave modport is the demux's view; the master modport is the source/sink environment's view.
interface demux1to2_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             last_i;
  logic             sel_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_o;
  logic             a_valid_o;
  logic             a_last_o;
  logic             a_ready_i;
  logic [WIDTH-1:0] b_o;
  logic             b_valid_o;
  logic             b_last_o;
  logic             b_ready_i;

  modport slave (
    input  data_i, valid_i, last_i, sel_i, a_ready_i, b_ready_i,
    output ready_o, a_o, a_valid_o, a_last_o, b_o, b_valid_o, b_last_o
  );

  modport master (
    output data_i, valid_i, last_i, sel_i, a_ready_i, b_ready_i,
    input  ready_o, a_o, a_valid_o, a_last_o, b_o, b_valid_o, b_last_o
  );
endinterface

// File: rtl/demux1to2.sv
// Packet-aware 1-to-2 demux: a packet's first beat picks channel A/B, later beats follow until last.
// Optional per-channel 16-bit output-transfer counters when DEMUX1TO2_CNT_EN is defined.
module demux1to2 #(
  parameter int WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  demux1to2_if.slave  bus
`ifdef DEMUX1TO2_CNT_EN
  ,
  output logic [15:0] cnt_a_o,
  output logic [15:0] cnt_b_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // Index 0 is channel A, index 1 is channel B.
  logic [1:0]       r_valid;
  logic [1:0]       r_last;
  logic [WIDTH-1:0] r_data [2];
  logic [1:0]       w_sink_rdy;
  logic [1:0]       w_free;
  logic [1:0]       w_load;
  logic             w_tgt_b;
  logic             w_ready;
  logic             w_accept;

  assign w_sink_rdy = {bus.b_ready_i, bus.a_ready_i};
  assign w_tgt_b    = (r_state == ST_LOCK_B) || ((r_state == ST_IDLE) && bus.sel_i);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_free
      assign w_free[gi] = !r_valid[gi] || w_sink_rdy[gi];
    end
  endgenerate

  // Gated by rst_ni so the source sees no acceptance while reset is held.
  assign w_ready   = rst_ni && (w_tgt_b ? w_free[1] : w_free[0]);
  assign w_accept  = bus.valid_i && w_ready;
  assign w_load[0] = w_accept && !w_tgt_b;
  assign w_load[1] = w_accept && w_tgt_b;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.last_i) begin
            w_state_next = bus.sel_i ? ST_LOCK_B : ST_LOCK_A;
          end
        end
        ST_LOCK_A, ST_LOCK_B: begin
          if (bus.last_i) begin
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Data/last only move on a load, so they stay stable while stalled and after draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_last  <= '0;
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= 1'b1;
          r_last[i]  <= bus.last_i;
          r_data[i]  <= bus.data_i;
        end else if (w_sink_rdy[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.ready_o   = w_ready;
  assign bus.a_o       = r_data[0];
  assign bus.a_valid_o = r_valid[0];
  assign bus.a_last_o  = r_last[0];
  assign bus.b_o       = r_data[1];
  assign bus.b_valid_o = r_valid[1];
  assign bus.b_last_o  = r_last[1];

`ifdef DEMUX1TO2_CNT_EN
  logic [15:0] r_cnt [2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_valid[i] && w_sink_rdy[i]) begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign cnt_a_o = r_cnt[0];
  assign cnt_b_o = r_cnt[1];
`endif

endmodule

// File: tb/tb_demux1to2.sv
// Randomized and directed bench for demux1to2 against a packet-routing scoreboard model.
// Counter checks are compiled in when DEMUX1TO2_CNT_EN is defined.
module tb_demux1to2;
  logic clk;
  logic rst_ni;

  demux1to2_if #(.WIDTH(8)) bus ();

`ifdef DEMUX1TO2_CNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  demux1to2 #(.WIDTH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
`ifdef DEMUX1TO2_CNT_EN
    ,
    .cnt_a_o(cnt_a),
    .cnt_b_o(cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: expected beat streams per channel, packet lock, last loaded beat per channel.
  logic [8:0]  q_a[$];
  logic [8:0]  q_b[$];
  logic [8:0]  held_a;
  logic [8:0]  held_b;
  int          lock;       // -1: between packets, 0: packet bound to A, 1: bound to B
  int unsigned m_cnt_a;
  int unsigned m_cnt_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_a.delete();
    q_b.delete();
    held_a  = '0;
    held_b  = '0;
    lock    = -1;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  // One clock cycle: drive at the falling edge, check just after, update model for the coming rising edge.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit s,
                      input bit ar, input bit br);
    bit tgt;
    bit exp_rdy;
    @(negedge clk);
    bus.valid_i   = v;
    bus.data_i    = d;
    bus.last_i    = l;
    bus.sel_i     = s;
    bus.a_ready_i = ar;
    bus.b_ready_i = br;
    #1;
    tgt     = (lock == 1) ? 1'b1 : ((lock == 0) ? 1'b0 : s);
    exp_rdy = tgt ? (q_b.size() == 0 || br) : (q_a.size() == 0 || ar);
    chk("ready", 32'(bus.ready_o), 32'(exp_rdy));

    chk("a_valid", 32'(bus.a_valid_o), 32'(q_a.size() != 0));
    chk("a_data", 32'(bus.a_o), 32'(q_a.size() != 0 ? q_a[0][7:0] : held_a[7:0]));
    chk("a_last", 32'(bus.a_last_o), 32'(q_a.size() != 0 ? q_a[0][8] : held_a[8]));
    chk("b_valid", 32'(bus.b_valid_o), 32'(q_b.size() != 0));
    chk("b_data", 32'(bus.b_o), 32'(q_b.size() != 0 ? q_b[0][7:0] : held_b[7:0]));
    chk("b_last", 32'(bus.b_last_o), 32'(q_b.size() != 0 ? q_b[0][8] : held_b[8]));
`ifdef DEMUX1TO2_CNT_EN
    chk("cnt_a", 32'(cnt_a), m_cnt_a % 65536);
    chk("cnt_b", 32'(cnt_b), m_cnt_b % 65536);
`endif

    if (q_a.size() != 0 && ar) begin
      void'(q_a.pop_front());
      m_cnt_a++;
    end
    if (q_b.size() != 0 && br) begin
      void'(q_b.pop_front());
      m_cnt_b++;
    end
    if (v && exp_rdy) begin
      if (tgt) begin
        q_b.push_back({l, d});
        held_b = {l, d};
      end else begin
        q_a.push_back({l, d});
        held_a = {l, d};
      end
      lock = l ? -1 : int'(tgt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni      = 1'b0;
    bus.valid_i = 1'b1;
    bus.sel_i   = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready_o), 32'd0);
    chk("rst_a_valid", 32'(bus.a_valid_o), 32'd0);
    chk("rst_b_valid", 32'(bus.b_valid_o), 32'd0);
    chk("rst_a_last", 32'(bus.a_last_o), 32'd0);
    chk("rst_b_last", 32'(bus.b_last_o), 32'd0);
    chk("rst_a_data", 32'(bus.a_o), 32'd0);
    chk("rst_b_data", 32'(bus.b_o), 32'd0);
`ifdef DEMUX1TO2_CNT_EN
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_cnt_b", 32'(cnt_b), 32'd0);
`endif
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_ready_hold", 32'(bus.ready_o), 32'd0);
    rst_ni      = 1'b1;
    bus.valid_i = 1'b0;
  endtask

  initial begin
    rst_ni        = 1'b0;
    bus.valid_i   = 1'b0;
    bus.data_i    = '0;
    bus.last_i    = 1'b0;
    bus.sel_i     = 1'b0;
    bus.a_ready_i = 1'b0;
    bus.b_ready_i = 1'b0;
    model_clear();
    do_reset();

    // Single beat to B, FSM stays IDLE so next beat follows sel_i.
    step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("single_b_data", 32'(bus.b_o), 32'h5A);
    chk("single_b_last", 32'(bus.b_last_o), 32'd1);
    chk("single_a_idle", 32'(bus.a_valid_o), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("single_next_a", 32'(bus.a_valid_o), 32'd1);

    // Packet lock: sel_i flips mid-packet but beats stay on A.
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("lock_third_on_a", 32'(bus.a_o), 32'h33);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("lock_next_on_b", 32'(bus.b_o), 32'h44);

    // Backpressure on A for four cycles.
    step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("bp_ready_low", 32'(bus.ready_o), 32'd0);
    repeat (3) step(1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("bp_hold_data", 32'(bus.a_o), 32'hA1);
    step(1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bp_second_beat", 32'(bus.a_o), 32'hA2);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // B stalled while A streams at full rate.
    step(1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("indep_ready", 32'(bus.ready_o), 32'd1);
    step(1'b1, 8'hC2, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("indep_ready_stream", 32'(bus.ready_o), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("indep_b_held", 32'(bus.b_valid_o), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset mid-packet to B; next beat routed by sel_i.
    step(1'b1, 8'hD1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'hD2, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 8'hE1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("post_rst_a_valid", 32'(bus.a_valid_o), 32'd1);
    chk("post_rst_a_data", 32'(bus.a_o), 32'hE1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

`ifdef DEMUX1TO2_CNT_EN
    // Counter wrap: 65537 output transfers on A.
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1, 1'b1);
    end
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("wrap_cnt_a", 32'(cnt_a), 32'd1);
    chk("wrap_cnt_b", 32'(cnt_b), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux1to2.md
DEMUX1TO2 -- requirements
Module: demux1to2

Interface
- REQ-001: Parameter WIDTH, default 8: data width of the input and both output channels.
- REQ-002: clk_i, input, 1: single clock; all state updates on its rising edge.
- REQ-003: rst_ni, input, 1: reset, asynchronous and active-low.
- REQ-004: data_i, input, WIDTH: input beat data.
- REQ-005: valid_i, input, 1: input beat valid.
- REQ-006: last_i, input, 1: input beat is the final beat of its packet.
- REQ-007: sel_i, input, 1: destination for a packet's first beat; 0 = channel A, 1 = channel B.
- REQ-008: ready_o, output, 1: block accepts the input beat this cycle.
- REQ-009: a_o / b_o, output, WIDTH: channel A / B data.
- REQ-010: a_valid_o / b_valid_o, output, 1: channel A / B beat valid.
- REQ-011: a_last_o / b_last_o, output, 1: channel A / B last-beat flag.
- REQ-012: a_ready_i / b_ready_i, input, 1: channel A / B sink accepts the beat.

Function
- REQ-013: An input beat SHALL transfer on a cycle with valid_i=1 and ready_o=1; an output beat SHALL transfer on a cycle with x_valid_o=1 and x_ready_i=1.
- REQ-014: Each channel SHALL hold a one-entry output register with data, last, and valid fields.
- REQ-015: An output register SHALL be "free" when x_valid_o=0, or when x_valid_o=1 and x_ready_i=1 in the same cycle.
- REQ-016: The FSM SHALL have three states: IDLE, LOCK_A, and LOCK_B.
- REQ-017: The routing target SHALL be sel_i in IDLE, A in LOCK_A, and B in LOCK_B.
- REQ-018: ready_o SHALL equal the free status of the target channel's register.
- REQ-019: ready_o SHALL be independent of valid_i and of the non-target channel.
- REQ-020: In IDLE, an accepted beat with last_i=0 SHALL move the FSM to LOCK_A (sel_i=0) or LOCK_B (sel_i=1).
- REQ-021: In IDLE, an accepted beat with last_i=1 SHALL leave the FSM in IDLE (single-beat packet).
- REQ-022: In LOCK_x, sel_i SHALL be ignored.
- REQ-023: In LOCK_x, an accepted beat with last_i=1 SHALL return the FSM to IDLE.
- REQ-024: In all states, no input transfer SHALL leave the FSM unchanged.
- REQ-025: An accepted beat SHALL appear on the target channel at the next rising edge, with data and last copied unchanged (latency 1 cycle).
- REQ-026: When the target register is free, one beat per cycle SHALL be sustained (full throughput).
- REQ-027: While x_valid_o=1 and x_ready_i=0, x_o and x_last_o SHALL remain stable.
- REQ-028: The non-target channel's register SHALL drain independently, and both channels MAY transfer in the same cycle.
- REQ-029: An output register that drains with no new beat loaded SHALL clear x_valid_o at the next edge; x_o and x_last_o SHALL hold their last value.
- REQ-030: Beats SHALL never be dropped, duplicated, or reordered within a channel.

Reset
- REQ-031: While rst_ni=0, the FSM SHALL be IDLE, and a_valid_o, b_valid_o, a_last_o, b_last_o, a_o and b_o SHALL be 0.
- REQ-032: While rst_ni=0, ready_o SHALL be 0.
- REQ-033: Asserting rst_ni mid-packet SHALL discard held beats and lock state; the first beat after release SHALL be routed by sel_i.

Configuration
- REQ-034: Macro DEMUX1TO2_CNT_EN, when defined, SHALL add outputs cnt_a_o and cnt_b_o.
- REQ-035: cnt_a_o and cnt_b_o SHALL each be 16-bit counts of channel A / B output transfers.
- REQ-036: Each counter SHALL reset to 0 and wrap from 0xFFFF to 0x0000.
- REQ-037: Without DEMUX1TO2_CNT_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-038: Reset then single beat: data_i=0x5A, sel_i=1, last_i=1, b_ready_i=1 -> b_o=0x5A, b_valid_o=1, b_last_o=1 one cycle later; a_valid_o stays 0; FSM stays IDLE.
- REQ-039: Packet lock: 3-beat packet 0x11, 0x22, 0x33 with sel_i=0 on beat 1, then sel_i=1 on beats 2–3 -> all three beats appear on A in order; the next packet is routed by sel_i.
- REQ-040: Backpressure: a_ready_i=0 for 4 cycles with 2-beat packet to A -> a_o=first beat is held stable; ready_o=0 after the first beat; a_ready_i=1 -> both beats delivered, no loss.
- REQ-041: Independence: B holding a stalled beat, new packet to A -> ready_o=1; A streams at 1 beat/cycle while b_valid_o stays 1.
- REQ-042: Reset mid-packet: assert rst_ni=0 after beat 2 of 4 to B -> all valids 0; after release, beat with sel_i=0 goes to A.
- REQ-043: With DEMUX1TO2_CNT_EN defined: 65537 beats to A -> cnt_a_o=1 and cnt_b_o=0.
